correcao_quadrante_saida_q16_32: RTL and testbench

- Post-processing stage for the CORDIC rotation core. It is the counterpart of the input quadrant-reduction stage.
- Takes the cos/sin results the core computed for the reduced angle z ∈ [-π/4, π/4], plus the 3-bit quadrant code produced at reduction.
- Reconstructs cos/sin of the original angle by swapping and negating.
- Rounds and saturates the Q16.32 results down to Q16.16 and issues a one-cycle done pulse.

---
 rtl/correcao_quadrante_saida_q16_32.sv | 165 ++++++++++++++++
 tb/tb_correcao_quadrante_saida_q16_32.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/correcao_quadrante_saida_q16_32.sv
`default_nettype none
// ============================================================================
// Module      : correcao_quadrante_saida_q16_32
// Description : CORDIC output quadrant correction; swaps/negates the reduced
//               cos/sin, then rounds and saturates Q16.32 down to Q16.16.
// Revision    : 1.0 - initial release
// ============================================================================
module correcao_quadrante_saida_q16_32 #(
    parameter int WIDTH           = 32,
    parameter int INTERNAL_WIDTH  = 48,
    parameter int FRACTIONAL_BITS = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic signed [INTERNAL_WIDTH-1:0] cos_in,
    input  logic signed [INTERNAL_WIDTH-1:0] sin_in,
    input  logic [2:0]                       quadrante,
    output logic signed [WIDTH-1:0]          cos_out,
    output logic signed [WIDTH-1:0]          sin_out,
    output logic                             busy,
    output logic                             erro,
    output logic                             done
);

    localparam int c_MW       = INTERNAL_WIDTH + 1;
    localparam int c_OUT_FRAC = WIDTH / 2;
    localparam int c_SHIFT    = FRACTIONAL_BITS - c_OUT_FRAC;

    localparam logic signed [c_MW-1:0] c_HALF = c_MW'(1) << (c_SHIFT - 1);
    localparam logic signed [c_MW-1:0] c_MAX  = {{(c_MW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [c_MW-1:0] c_MIN  = {{(c_MW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAP  = 2'd1,
        S_CONV = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [INTERNAL_WIDTH-1:0] r_cos_lat;
    logic signed [INTERNAL_WIDTH-1:0] r_sin_lat;
    logic [2:0]                       r_quad;
    logic signed [c_MW-1:0]           r_c_map;
    logic signed [c_MW-1:0]           r_s_map;
    logic                             r_erro_pend;
    logic signed [WIDTH-1:0]          r_cos_out;
    logic signed [WIDTH-1:0]          r_sin_out;
    logic                             r_erro;
    logic                             r_done;

    logic signed [c_MW-1:0] w_cos_x;
    logic signed [c_MW-1:0] w_sin_x;
    logic signed [c_MW-1:0] w_c_map;
    logic signed [c_MW-1:0] w_s_map;
    logic                   w_map_err;
    logic [WIDTH-1:0]       w_cos_sat;
    logic [WIDTH-1:0]       w_sin_sat;

    // Round half toward +inf, then clamp to the Q16.16 range.
    function automatic logic [WIDTH-1:0] f_round_sat(input logic signed [c_MW-1:0] v);
        logic signed [c_MW-1:0] sh;
        sh = (v + c_HALF) >>> c_SHIFT;
        if (sh > c_MAX)
            return {1'b0, {(WIDTH-1){1'b1}}};
        else if (sh < c_MIN)
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return sh[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (enable) w_next = S_MAP;
            S_MAP:   w_next = S_CONV;
            S_CONV:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // One extra sign bit so negating the most negative input cannot wrap.
    assign w_cos_x = {r_cos_lat[INTERNAL_WIDTH-1], r_cos_lat};
    assign w_sin_x = {r_sin_lat[INTERNAL_WIDTH-1], r_sin_lat};

    always_comb begin
        w_c_map   = w_cos_x;
        w_s_map   = w_sin_x;
        w_map_err = 1'b0;
        case (r_quad)
            3'b000: ;
            3'b001: begin
                w_c_map = -w_sin_x;
                w_s_map = w_cos_x;
            end
            3'b010, 3'b011: begin
                w_c_map = -w_cos_x;
                w_s_map = -w_sin_x;
            end
            3'b100: begin
                w_c_map = w_sin_x;
                w_s_map = -w_cos_x;
            end
            default: w_map_err = 1'b1;
        endcase
    end

    assign w_cos_sat = f_round_sat(r_c_map);
    assign w_sin_sat = f_round_sat(r_s_map);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cos_lat   <= '0;
            r_sin_lat   <= '0;
            r_quad      <= '0;
            r_c_map     <= '0;
            r_s_map     <= '0;
            r_erro_pend <= 1'b0;
            r_cos_out   <= '0;
            r_sin_out   <= '0;
            r_erro      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (enable) begin
                        r_cos_lat <= cos_in;
                        r_sin_lat <= sin_in;
                        r_quad    <= quadrante;
                    end
                end
                S_MAP: begin
                    r_c_map     <= w_c_map;
                    r_s_map     <= w_s_map;
                    r_erro_pend <= w_map_err;
                end
                S_CONV: begin
                    r_cos_out <= w_cos_sat;
                    r_sin_out <= w_sin_sat;
                    r_erro    <= r_erro_pend;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cos_out = r_cos_out;
    assign sin_out = r_sin_out;
    assign erro    = r_erro;
    assign done    = r_done;
    assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_correcao_quadrante_saida_q16_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_correcao_quadrante_saida_q16_32
// Description : Self-checking bench with a cycle-level reference model and
//               directed vectors for the output quadrant correction stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_correcao_quadrante_saida_q16_32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [47:0] cos_in = '0;
    logic [47:0] sin_in = '0;
    logic [2:0]  quadrante = '0;
    logic [31:0] cos_out;
    logic [31:0] sin_out;
    logic        busy;
    logic        erro;
    logic        done;

    int checks = 0;
    int errors = 0;

    correcao_quadrante_saida_q16_32 #(
        .WIDTH(32), .INTERNAL_WIDTH(48), .FRACTIONAL_BITS(32)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .cos_in(cos_in), .sin_in(sin_in), .quadrante(quadrante),
        .cos_out(cos_out), .sin_out(sin_out),
        .busy(busy), .erro(erro), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: real-valued meaning of the quadrant codes.
    function automatic logic [31:0] round_sat(input longint v);
        longint r;
        r = (v + 64'sd32768) >>> 16;
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
        return r[31:0];
    endfunction

    task automatic model_calc(input logic [47:0] c, input logic [47:0] s, input logic [2:0] q,
                              output logic [31:0] oc, output logic [31:0] os, output logic oe);
        longint cv, sv, cr, sr;
        cv = longint'($signed(c));
        sv = longint'($signed(s));
        oe = 1'b0;
        case (q)
            3'd1:       begin cr = -sv; sr = cv;  end
            3'd2, 3'd3: begin cr = -cv; sr = -sv; end
            3'd4:       begin cr = sv;  sr = -cv; end
            3'd0:       begin cr = cv;  sr = sv;  end
            default:    begin cr = cv;  sr = sv; oe = 1'b1; end
        endcase
        oc = round_sat(cr);
        os = round_sat(sr);
    endtask

    // Model: an accepted request occupies two further cycles, then results + done.
    int          m_cnt = 0;
    logic [31:0] m_cos = '0, m_sin = '0, p_cos, p_sin;
    logic        m_erro = 1'b0, m_done = 1'b0, p_erro;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0; m_cos = '0; m_sin = '0; m_erro = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (enable) begin
                    model_calc(cos_in, sin_in, quadrante, p_cos, p_sin, p_erro);
                    m_cnt = 2;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_cos = p_cos; m_sin = p_sin; m_erro = p_erro; m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cos_out", {32'd0, cos_out}, {32'd0, m_cos});
        chk("sin_out", {32'd0, sin_out}, {32'd0, m_sin});
        chk("erro", {63'd0, erro}, {63'd0, m_erro});
        chk("done", {63'd0, done}, {63'd0, m_done});
        chk("busy", {63'd0, busy}, {63'd0, (m_cnt != 0)});
    end

    int done_seen = 0;

    // One request with literal expectations; optional disturbance during MAP.
    task automatic run_op(input string name, input logic [47:0] c, input logic [47:0] s,
                          input logic [2:0] q, input logic [31:0] ec, input logic [31:0] es,
                          input logic ee, input bit disturb);
        int lat;
        @(negedge clk);
        cos_in = c; sin_in = s; quadrante = q; enable = 1'b1;
        lat = 0;
        done_seen = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1 && disturb) begin
                enable = 1'b1;
                cos_in = 48'h1234_5678_9ABC; sin_in = 48'hFEDC_BA98_7654; quadrante = 3'd2;
            end else begin
                enable = 1'b0;
            end
        end while (!done && lat < 10);
        if (!done) begin
            chk({name, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({name, "_latency"}, 64'(lat), 64'd3);
            chk({name, "_cos"}, {32'd0, cos_out}, {32'd0, ec});
            chk({name, "_sin"}, {32'd0, sin_out}, {32'd0, es});
            chk({name, "_erro"}, {63'd0, erro}, {63'd0, ee});
        end
        if (disturb) begin
            done_seen = 1;
            repeat (6) begin
                @(negedge clk);
                if (done) done_seen++;
            end
            chk({name, "_single_done"}, 64'(done_seen), 64'd1);
        end
    endtask

    initial begin
        int n;
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            enable = 1'($urandom);
            cos_in = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            sin_in = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            quadrante = 3'($urandom);
        end
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_cos", {32'd0, cos_out}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        run_op("q001", 48'h0000_8000_0000, 48'h0000_4000_0000, 3'd1, 32'hFFFFC000, 32'h00008000, 1'b0, 1'b0);
        run_op("q000", 48'h0001_0000_0000, 48'h0, 3'd0, 32'h00010000, 32'h0, 1'b0, 1'b0);
        run_op("q1u",  48'h0001_0000_0000, 48'h0, 3'd1, 32'h0, 32'h00010000, 1'b0, 1'b0);
        run_op("q010", 48'h0001_0000_0000, 48'h0, 3'd2, 32'hFFFF0000, 32'h0, 1'b0, 1'b0);
        run_op("q011", 48'h0001_0000_0000, 48'h0, 3'd3, 32'hFFFF0000, 32'h0, 1'b0, 1'b0);
        run_op("q100", 48'h0001_0000_0000, 48'h0, 3'd4, 32'h0, 32'hFFFF0000, 1'b0, 1'b0);
        run_op("q101", 48'h0001_0000_0000, 48'h0, 3'd5, 32'h00010000, 32'h0, 1'b1, 1'b0);
        run_op("q111", 48'h0000_0000_0000, 48'h0000_8000_0000, 3'd7, 32'h0, 32'h00008000, 1'b1, 1'b0);
        run_op("rnd_up", 48'h0000_0000_8000, 48'h0, 3'd0, 32'h1, 32'h0, 1'b0, 1'b0);
        run_op("rnd_neg", 48'hFFFF_FFFF_8000, 48'h0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        run_op("sat_sin", 48'h0, 48'h7FFF_FFFF_FFFF, 3'd0, 32'h0, 32'h7FFFFFFF, 1'b0, 1'b0);
        run_op("sat_neg_cos", 48'h8000_0000_0000, 48'h0, 3'd2, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b0);
        run_op("min_cos", 48'h8000_0000_0000, 48'h0, 3'd0, 32'h80000000, 32'h0, 1'b0, 1'b0);
        run_op("disturb", 48'h0000_8000_0000, 48'h0000_4000_0000, 3'd1, 32'hFFFFC000, 32'h00008000, 1'b0, 1'b1);

        // Continuous enable: a result every third cycle.
        @(negedge clk);
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            cos_in = 48'h0000_4000_0000 + 48'(i) * 48'h0000_0001_0000;
            sin_in = 48'hFFFF_C000_0000;
            quadrante = 3'(i % 5);
            @(negedge clk);
            if (done) n++;
        end
        enable = 1'b0;
        chk("b2b_dones", 64'(n), 64'd3);

        // Abort in MAP: outputs clear at once, no done follows.
        run_op("pre_abort", 48'h0002_0000_0000, 48'h0, 3'd0, 32'h00020000, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        cos_in = 48'h0003_0000_0000; quadrante = 3'd0; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("abort_cos", {32'd0, cos_out}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("abort_no_done", 64'(n), 64'd0);
        run_op("post_abort", 48'h0000_C000_0000, 48'h0000_2000_0000, 3'd4, 32'h00002000, 32'hFFFF4000, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
